// File: rtl/chess_turn_ctrl_pkg.sv
// rtl/chess_turn_ctrl_pkg.sv - chess clock state encoding shared with display logic
package chess_clk_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    SETUP  = 3'd0,
    RUN1   = 3'd1,
    RUN2   = 3'd2,
    PAUSE1 = 3'd3,
    PAUSE2 = 3'd4,
    DONE   = 3'd5
  } state_t;

  function automatic logic is_running(state_t s);
    return (s == RUN1) || (s == RUN2);
  endfunction

endpackage

// File: rtl/chess_turn_ctrl_if.sv
// rtl/chess_turn_ctrl_if.sv - sequencer to timer datapath signal bundle (tick, times, strobes)
interface chess_turn_ctrl_if #(
  parameter int TW = 4
);
  logic          TICK;
  logic [TW-1:0] TIM1;
  logic [TW-1:0] TIM2;
  logic          CE;
  logic          PLAYER;
  logic          STOP;
  logic          SWITCH_TIM;

  modport master (
    input  TICK, TIM1, TIM2,
    output CE, PLAYER, STOP, SWITCH_TIM
  );

  modport slave (
    output TICK, TIM1, TIM2,
    input  CE, PLAYER, STOP, SWITCH_TIM
  );
endinterface

// File: rtl/chess_turn_ctrl_btn_sync_edge.sv
// rtl/chess_turn_ctrl_btn_sync_edge.sv - button synchroniser with registered rising-edge pulse
// Pulse is high SYNC_STAGES+1 cycles after the pin rises; a held button yields one pulse.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic CLR,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   last;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sync  <= '0;
      last  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn};
      last  <= sync[SYNC_STAGES-1];
      pulse <= sync[SYNC_STAGES-1] & ~last;
    end
  end

endmodule

// File: rtl/chess_turn_ctrl.sv
// rtl/chess_turn_ctrl.sv - chess clock game sequencer driving the down-counting timer datapath
// Optional MOVE_CNT output (saturating move counter) is built when MOVE_CNT_EN is defined.
module chess_turn_ctrl
  import chess_clk_pkg::*;
#(
  parameter int TW          = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               CLR,
  chess_turn_ctrl_if.master  dp,
  input  logic               BTN_START,
  input  logic               BTN_SET,
  input  logic               BTN_P1,
  input  logic               BTN_P2,
  output logic               FLAG1,
  output logic               FLAG2,
  output logic [STATE_W-1:0] STATE
`ifdef MOVE_CNT_EN
  ,
  output logic [7:0]         MOVE_CNT
`endif
);

  localparam logic [TW-1:0] TIM_ZERO = '0;

  state_t state;
  logic   start_ev;
  logic   set_ev;
  logic   p1_ev;
  logic   p2_ev;
  logic   time_out;
  logic   flag_fall;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (.CLK(CLK), .CLR(CLR), .btn(BTN_START), .pulse(start_ev));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_set   (.CLK(CLK), .CLR(CLR), .btn(BTN_SET),   .pulse(set_ev));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_p1    (.CLK(CLK), .CLR(CLR), .btn(BTN_P1),    .pulse(p1_ev));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_p2    (.CLK(CLK), .CLR(CLR), .btn(BTN_P2),    .pulse(p2_ev));

  // A tick on an already-zero clock is the flag; suppressing CE keeps the counter from wrapping.
  assign time_out  = ((state == RUN1) && (dp.TIM1 == TIM_ZERO)) ||
                     ((state == RUN2) && (dp.TIM2 == TIM_ZERO));
  assign flag_fall = dp.TICK && time_out;
  assign dp.CE     = dp.TICK && is_running(state) && !time_out;
  assign STATE     = state;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state         <= SETUP;
      dp.PLAYER     <= 1'b1;
      dp.STOP       <= 1'b0;
      dp.SWITCH_TIM <= 1'b0;
      FLAG1         <= 1'b0;
      FLAG2         <= 1'b0;
    end else begin
      dp.STOP       <= 1'b0;
      dp.SWITCH_TIM <= 1'b0;
      case (state)
        SETUP: begin
          if (start_ev) begin
            state     <= RUN1;
            dp.PLAYER <= 1'b1;
          end else if (set_ev) begin
            dp.SWITCH_TIM <= 1'b1;
          end
        end
        RUN1: begin
          if (flag_fall) begin
            FLAG1   <= 1'b1;
            dp.STOP <= 1'b1;
            state   <= DONE;
          end else if (start_ev) begin
            state <= PAUSE1;
          end else if (p1_ev) begin
            state     <= RUN2;
            dp.PLAYER <= 1'b0;
          end
        end
        RUN2: begin
          if (flag_fall) begin
            FLAG2   <= 1'b1;
            dp.STOP <= 1'b1;
            state   <= DONE;
          end else if (start_ev) begin
            state <= PAUSE2;
          end else if (p2_ev) begin
            state     <= RUN1;
            dp.PLAYER <= 1'b1;
          end
        end
        PAUSE1: if (start_ev) state <= RUN1;
        PAUSE2: if (start_ev) state <= RUN2;
        DONE:   ;
        default: begin
          state     <= SETUP;
          dp.PLAYER <= 1'b1;
        end
      endcase
    end
  end

`ifdef MOVE_CNT_EN
  logic move_taken;

  assign move_taken = !flag_fall && !start_ev &&
                      (((state == RUN1) && p1_ev) || ((state == RUN2) && p2_ev));

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      MOVE_CNT <= 8'd0;
    end else if (move_taken && (MOVE_CNT != 8'hFF)) begin
      MOVE_CNT <= MOVE_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// tb/tb_chess_turn_ctrl.sv - self-checking bench for chess_turn_ctrl against a game-level model
`timescale 1ns/1ps
module tb_chess_turn_ctrl;
  import chess_clk_pkg::*;

  localparam int TW = 4;
  localparam int SS = 2;
  localparam int PH_SETUP = 0, PH_RUN = 1, PH_PAUSE = 2, PH_DONE = 3;

  logic               CLK = 1'b0;
  logic               CLR = 1'b0;
  logic [3:0]         pins;  // 0 START, 1 SET, 2 P1, 3 P2
  logic               BTN_START, BTN_SET, BTN_P1, BTN_P2;
  logic               FLAG1, FLAG2;
  logic [STATE_W-1:0] STATE;
`ifdef MOVE_CNT_EN
  logic [7:0]         MOVE_CNT;
`endif

  chess_turn_ctrl_if #(.TW(TW)) dp ();

  assign {BTN_P2, BTN_P1, BTN_SET, BTN_START} = pins;

  chess_turn_ctrl #(.TW(TW), .SYNC_STAGES(SS)) dut (
    .CLK(CLK), .CLR(CLR), .dp(dp),
    .BTN_START(BTN_START), .BTN_SET(BTN_SET), .BTN_P1(BTN_P1), .BTN_P2(BTN_P2),
    .FLAG1(FLAG1), .FLAG2(FLAG2), .STATE(STATE)
`ifdef MOVE_CNT_EN
    , .MOVE_CNT(MOVE_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int chk = 0, pass = 0, cyc = 0;
  int ce_n = 0, sw_n = 0, sw_rise = 0;
  logic sw_prev = 1'b0;

  // Game model: phase plus whose clock is active, times, flags, move count.
  int   m_phase, m_t1, m_t2, m_mc;
  logic m_pl, m_f1, m_f2, m_stop, m_sw;
  int   evq[4][$];

  always @(negedge CLK) begin
    if (dp.CE === 1'b1) ce_n++;
    if (dp.SWITCH_TIM === 1'b1) sw_n++;
    if (dp.SWITCH_TIM === 1'b1 && !sw_prev) sw_rise++;
    sw_prev = (dp.SWITCH_TIM === 1'b1);
  end

  function automatic logic [STATE_W-1:0] m_code();
    case (m_phase)
      PH_SETUP: return SETUP;
      PH_RUN:   return m_pl ? RUN1 : RUN2;
      PH_PAUSE: return m_pl ? PAUSE1 : PAUSE2;
      default:  return DONE;
    endcase
  endfunction

  function automatic logic m_flag();
    return (dp.TICK === 1'b1) && (m_phase == PH_RUN) && (m_pl ? (m_t1 == 0) : (m_t2 == 0));
  endfunction

  function automatic logic m_ce();
    return (dp.TICK === 1'b1) && (m_phase == PH_RUN) && !m_flag();
  endfunction

  task automatic m_reset(input int t1, input int t2);
    m_phase = PH_SETUP; m_pl = 1'b1; m_f1 = 1'b0; m_f2 = 1'b0;
    m_stop = 1'b0; m_sw = 1'b0; m_mc = 0; m_t1 = t1; m_t2 = t2;
    for (int b = 0; b < 4; b++) evq[b].delete();
    dp.TIM1 = TW'(t1); dp.TIM2 = TW'(t2);
  endtask

  task automatic model_edge();
    logic ev [4];
    logic fl, ce;
    for (int b = 0; b < 4; b++) begin
      ev[b] = (evq[b].size() > 0) && (evq[b][0] == cyc + 1);
      if (ev[b]) void'(evq[b].pop_front());
    end
    fl = m_flag();
    ce = m_ce();
    m_stop = 1'b0;
    m_sw   = 1'b0;
    if (!CLR) begin
      if (fl) begin
        if (m_pl) m_f1 = 1'b1; else m_f2 = 1'b1;
        m_stop  = 1'b1;
        m_phase = PH_DONE;
      end else begin
        if (ce) begin
          if (m_pl) m_t1--; else m_t2--;
        end
        case (m_phase)
          PH_SETUP: if (ev[0]) m_phase = PH_RUN; else if (ev[1]) m_sw = 1'b1;
          PH_RUN: begin
            if (ev[0]) m_phase = PH_PAUSE;
            else if (m_pl ? ev[2] : ev[3]) begin
              m_pl = !m_pl;
              if (m_mc < 255) m_mc++;
            end
          end
          PH_PAUSE: if (ev[0]) m_phase = PH_RUN;
          default: ;
        endcase
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    dp.TIM1 = TW'(m_t1);
    dp.TIM2 = TW'(m_t2);
    dp.TICK = 1'b0;
  endtask

  task automatic set_pins(input logic [3:0] v);
    for (int b = 0; b < 4; b++)
      if (v[b] && !pins[b]) evq[b].push_back(cyc + SS + 2);
    pins = v;
  endtask

  task automatic tap(input int b);
    set_pins(pins | 4'(1 << b));
    step();
    set_pins(pins & ~4'(1 << b));
    repeat (SS + 1) step();
  endtask

  task automatic do_reset(input int t1, input int t2);
    CLR  = 1'b1;
    pins = '0;
    m_reset(t1, t2);
    step();
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    #2 CLR = 1'b1;
    m_reset(9, 9);
    dp.TICK = 1'b1;
    #1;
    chk++; if (STATE !== 3'd0) $display("FAIL reset_state got %0d want 0", STATE); else pass++;
    chk++; if (dp.PLAYER !== 1'b1) $display("FAIL reset_player got %b want 1", dp.PLAYER); else pass++;
    chk++; if (dp.CE !== 1'b0) $display("FAIL reset_ce got %b want 0", dp.CE); else pass++;
    chk++; if (dp.STOP !== 1'b0 || dp.SWITCH_TIM !== 1'b0) $display("FAIL reset_pulses got %b%b want 00", dp.STOP, dp.SWITCH_TIM); else pass++;
    chk++; if (FLAG1 !== 1'b0 || FLAG2 !== 1'b0) $display("FAIL reset_flags got %b%b want 00", FLAG1, FLAG2); else pass++;
`ifdef MOVE_CNT_EN
    chk++; if (MOVE_CNT !== 8'd0) $display("FAIL reset_move_cnt got %0d want 0", MOVE_CNT); else pass++;
`endif
    step();
    CLR = 1'b0;
  endtask

  task automatic test_setup_switch();
    int sw0 = sw_n, rise0 = sw_rise, ce0 = ce_n;
    repeat (3) begin
      tap(1);
      dp.TICK = 1'b1;
      step();
    end
    step();
    chk++; if (sw_n - sw0 !== 3) $display("FAIL setup_switch_cycles got %0d want 3", sw_n - sw0); else pass++;
    chk++; if (sw_rise - rise0 !== 3) $display("FAIL setup_switch_pulses got %0d want 3", sw_rise - rise0); else pass++;
    chk++; if (STATE !== 3'd0) $display("FAIL setup_state got %0d want 0", STATE); else pass++;
    chk++; if (ce_n - ce0 !== 0) $display("FAIL setup_ce got %0d want 0", ce_n - ce0); else pass++;
  endtask

  task automatic test_run_ticks();
    int ce0;
    tap(0);
    chk++; if (STATE !== 3'd1 || dp.PLAYER !== 1'b1) $display("FAIL start_run1 got %0d/%b want 1/1", STATE, dp.PLAYER); else pass++;
    ce0 = ce_n;
    repeat (5) begin
      dp.TICK = 1'b1;
      step();
      step();
    end
    chk++; if (ce_n - ce0 !== 5) $display("FAIL run1_ce_count got %0d want 5", ce_n - ce0); else pass++;
    tap(2);
    chk++; if (STATE !== 3'd2 || dp.PLAYER !== 1'b0) $display("FAIL p1_switch got %0d/%b want 2/0", STATE, dp.PLAYER); else pass++;
    dp.TICK = 1'b1;
    @(negedge CLK);
    chk++; if (dp.CE !== 1'b1) $display("FAIL run2_ce got %b want 1", dp.CE); else pass++;
    step();
    tap(2);
    chk++; if (STATE !== 3'd2 || dp.PLAYER !== 1'b0) $display("FAIL p1_ignored got %0d/%b want 2/0", STATE, dp.PLAYER); else pass++;
  endtask

  task automatic test_pause();
    int ce0;
    tap(0);
    chk++; if (STATE !== 3'd4) $display("FAIL pause2_state got %0d want 4", STATE); else pass++;
    ce0 = ce_n;
    repeat (3) begin
      dp.TICK = 1'b1;
      step();
      step();
    end
    chk++; if (ce_n - ce0 !== 0) $display("FAIL pause_ce got %0d want 0", ce_n - ce0); else pass++;
    tap(0);
    chk++; if (STATE !== 3'd2 || dp.PLAYER !== 1'b0) $display("FAIL resume_run2 got %0d/%b want 2/0", STATE, dp.PLAYER); else pass++;
  endtask

  task automatic test_flag();
    tap(3);
    m_t1 = 0;
    dp.TIM1 = '0;
    dp.TICK = 1'b1;
    @(negedge CLK);
    chk++; if (dp.CE !== 1'b0) $display("FAIL flag_ce got %b want 0", dp.CE); else pass++;
    step();
    chk++; if (STATE !== 3'd5 || FLAG1 !== 1'b1 || FLAG2 !== 1'b0) $display("FAIL flag1_done got %0d/%b%b want 5/10", STATE, FLAG1, FLAG2); else pass++;
    chk++; if (dp.STOP !== 1'b1) $display("FAIL flag_stop got %b want 1", dp.STOP); else pass++;
    step();
    chk++; if (dp.STOP !== 1'b0) $display("FAIL stop_width got %b want 0", dp.STOP); else pass++;
    for (int b = 0; b < 4; b++) tap(b);
    chk++; if (STATE !== 3'd5 || dp.PLAYER !== 1'b1 || FLAG1 !== 1'b1) $display("FAIL done_sticky got %0d/%b/%b want 5/1/1", STATE, dp.PLAYER, FLAG1); else pass++;
  endtask

  task automatic test_flag_vs_move();
    do_reset(5, 5);
    tap(0);
    m_t1 = 0;
    dp.TIM1 = '0;
    set_pins(4'b0100);
    step();
    set_pins(4'b0000);
    repeat (SS) step();
    dp.TICK = 1'b1;
    step();
    chk++; if (STATE !== 3'd5 || FLAG1 !== 1'b1) $display("FAIL flag_wins got %0d/%b want 5/1", STATE, FLAG1); else pass++;
    chk++; if (dp.PLAYER !== 1'b1) $display("FAIL flag_no_switch got %b want 1", dp.PLAYER); else pass++;
  endtask

  task automatic test_clr_mid();
    do_reset(9, 9);
    tap(0);
    tap(2); tap(3); tap(2); tap(3);
`ifdef MOVE_CNT_EN
    chk++; if (MOVE_CNT !== 8'd4) $display("FAIL move_cnt_4 got %0d want 4", MOVE_CNT); else pass++;
`endif
    tap(2);
    chk++; if (STATE !== 3'd2) $display("FAIL pre_clr_state got %0d want 2", STATE); else pass++;
    dp.TICK = 1'b1;
    #2 CLR = 1'b1;
    #1;
    chk++; if (STATE !== 3'd0 || dp.PLAYER !== 1'b1 || dp.CE !== 1'b0) $display("FAIL clr_mid got %0d/%b/%b want 0/1/0", STATE, dp.PLAYER, dp.CE); else pass++;
`ifdef MOVE_CNT_EN
    chk++; if (MOVE_CNT !== 8'd0) $display("FAIL clr_move_cnt got %0d want 0", MOVE_CNT); else pass++;
`endif
    m_reset(9, 9);
    step();
    CLR = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] v;
    int done_wait = 0;
    for (int i = 0; i < 2500; i++) begin
      if (m_phase == PH_DONE) done_wait++;
      if (done_wait > 8 || $urandom_range(0, 599) == 0) begin
        done_wait = 0;
        do_reset(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end
      for (int b = 0; b < 4; b++)
        v[b] = pins[b] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      set_pins(v);
      dp.TICK = ($urandom_range(0, 2) == 0);
      @(negedge CLK);
      chk++; if (STATE !== m_code()) $display("FAIL rnd_state @%0d got %0d want %0d", i, STATE, m_code()); else pass++;
      chk++; if (dp.PLAYER !== m_pl) $display("FAIL rnd_player @%0d got %b want %b", i, dp.PLAYER, m_pl); else pass++;
      chk++; if (dp.CE !== m_ce()) $display("FAIL rnd_ce @%0d got %b want %b", i, dp.CE, m_ce()); else pass++;
      chk++; if (dp.STOP !== m_stop) $display("FAIL rnd_stop @%0d got %b want %b", i, dp.STOP, m_stop); else pass++;
      chk++; if (dp.SWITCH_TIM !== m_sw) $display("FAIL rnd_switch @%0d got %b want %b", i, dp.SWITCH_TIM, m_sw); else pass++;
      chk++; if (FLAG1 !== m_f1 || FLAG2 !== m_f2) $display("FAIL rnd_flags @%0d got %b%b want %b%b", i, FLAG1, FLAG2, m_f1, m_f2); else pass++;
`ifdef MOVE_CNT_EN
      chk++; if (MOVE_CNT !== 8'(m_mc)) $display("FAIL rnd_move_cnt @%0d got %0d want %0d", i, MOVE_CNT, m_mc); else pass++;
`endif
      step();
    end
  endtask

  initial begin
    pins    = '0;
    dp.TICK = 1'b0;
    dp.TIM1 = '0;
    dp.TIM2 = '0;
    test_reset();
    test_setup_switch();
    test_run_ticks();
    test_pause();
    test_flag();
    test_flag_vs_move();
    test_clr_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
